// File: rtl/timer_arbiter.sv
// timer_arbiter: 4-way arbiter that times each grant for max_bus[i] cycles and pulses done on completion.
// Define TIMER_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module timer_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] max_bus,
    output logic [3:0]         gnt,
    output logic [3:0]         done,
    output logic               busy,
    output logic [WIDTH-1:0]   cnt
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] max_q;
    logic [1:0]       win;
    logic [3:0]       win_oh;
`ifdef TIMER_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] idx;
    // descending loop so the candidate nearest rr_ptr+1 is written last and wins
    always_comb begin
        win = 2'd0;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr + 2'd1 + 2'(k);
            if (req[idx]) win = idx;
        end
    end
`else
    always_comb begin
        win = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (req[k]) win = 2'(k);
    end
`endif
    assign win_oh = 4'b0001 << win;
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            max_q <= '0;
`ifdef TIMER_ARB_RR_EN
            rr_ptr <= 2'd3;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: if (|req) begin
                    state <= COUNT;
                    gnt   <= win_oh;
                    max_q <= max_bus[win*WIDTH +: WIDTH];
                    cnt   <= '0;
                    busy  <= 1'b1;
`ifdef TIMER_ARB_RR_EN
                    rr_ptr <= win;
`endif
                end
                // abort beats reach: a dropped request never earns a done pulse
                COUNT: if (~|(req & gnt)) begin
                    state <= IDLE;
                    gnt   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else if (cnt >= max_q) begin
                    state <= DONE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
                DONE: begin
                    state <= IDLE;
                    done  <= gnt;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed and random stimulus checked against a grant-timeline model.
// The model tracks edges elapsed since each grant instead of FSM states.
module tb_timer_arbiter;
    localparam int W = 4;
    logic           clk = 1'b0;
    logic           nRst = 1'b0;
    logic [3:0]     req = '0;
    logic [4*W-1:0] max_bus = '0;
    logic [3:0]     gnt, done;
    logic           busy;
    logic [W-1:0]   cnt;
    int tests = 0, fails = 0;
    bit active = 1'b0;
    int w = 0, m = 0, t = 0, rr = 3;
    logic [3:0] exp_done = '0;

    always #5 clk = ~clk;

    timer_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .nRst(nRst), .req(req), .max_bus(max_bus),
        .gnt(gnt), .done(done), .busy(busy), .cnt(cnt)
    );

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(logic [3:0] r);
`ifdef TIMER_ARB_RR_EN
        for (int k = 1; k <= 4; k++) if (r[(rr + k) % 4]) return (rr + k) % 4;
`else
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`endif
        return rr;
    endfunction

    // Grant at offset 0; cnt = t for t<=m, then one DONE-state edge, done pulse at t=m+2.
    task automatic step();
        @(posedge clk);
        exp_done = '0;
        if (!active) begin
            if (req != 4'b0) begin
                w = pick(req);
                m = int'(max_bus[w*W +: W]);
                t = 0;
                active = 1'b1;
                rr = w;
            end
        end else begin
            t++;
            if (t <= m + 1 && !req[w]) active = 1'b0;
            else if (t == m + 2) begin
                active = 1'b0;
                exp_done = 4'(1 << w);
            end
        end
        #1;
        check("gnt", 16'(gnt), active ? 16'(1 << w) : 16'h0);
        check("done", 16'(done), 16'(exp_done));
        check("busy", 16'(busy), 16'(active));
        check("cnt", 16'(cnt), (active && t <= m) ? 16'(t) : 16'h0);
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero(string tag);
        check({tag, "_gnt"}, 16'(gnt), 16'h0);
        check({tag, "_done"}, 16'(done), 16'h0);
        check({tag, "_busy"}, 16'(busy), 16'h0);
        check({tag, "_cnt"}, 16'(cnt), 16'h0);
    endtask

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        nRst = 1'b1;
        // single request, threshold 3
        req = 4'b0001; max_bus = 16'h0003;
        steps(7);
        req = 4'b0000; steps(2);
        // threshold 0
        req = 4'b0010; max_bus = 16'h0000;
        steps(4);
        req = 4'b0000; steps(2);
        // abort at cnt=4
        req = 4'b0100; max_bus = 16'h0A00;
        steps(5);
        req = 4'b0000; steps(3);
        // all requesting, all thresholds 1
        req = 4'b1111; max_bus = 16'h1111;
        steps(25);
        req = 4'b0000; steps(3);
        // all-ones threshold, latched value held while max_bus moves
        req = 4'b1000; max_bus = 16'hF000;
        step();
        max_bus = 16'h1000;
        steps(19);
        req = 4'b0000; steps(2);
        // async reset at cnt=5
        req = 4'b0001; max_bus = 16'h0009;
        steps(6);
        #2 nRst = 1'b0;
        #1 check_zero("async_rst");
        active = 1'b0; rr = 3;
        @(negedge clk);
        nRst = 1'b1;
        req = 4'b0000; steps(2);
        req = 4'b0001; max_bus = 16'h0003;
        steps(7);
        // random traffic with sticky requests and wandering thresholds
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) req = 4'($urandom);
            if ($urandom_range(3) == 0) max_bus = {4{4'($urandom_range(5))}} ^ 16'($urandom & 32'h1111);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
